vector_sweep_ctrl: RTL

- Controller that sequences an exhaustive input sweep of a small combinational/sequential DUT.
- Drives every N_W-bit vector from 0 to 2^N_W-1 and waits a programmable settle time per vector.
- Samples the DUT response, compacts all responses into a MISR signature and counts responses with bit 0 set.
- Replaces free-running bench stimulus loops in the trojan-detection flow with a synthesizable start/done engine.

---
 rtl/vector_sweep_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input-sweep engine: applies 0..2^N_W-1, settles, samples, MISR-compacts responses.
// Optional response log (2^N_W x OUT_W) built when VSWEEP_LOG_EN is defined.
module vector_sweep_ctrl #(
    parameter int               N_W    = 4,
    parameter int               OUT_W  = 1,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = 16'h8005,
    parameter logic [SIG_W-1:0] SEED   = 16'h0000
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [N_W-1:0]   vec_out,
    output logic             vec_valid,
    input  logic [OUT_W-1:0] dut_out,
    output logic             sample_strobe,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature,
    output logic [N_W:0]     ones_count,
    input  logic [N_W-1:0]   rd_addr,
    output logic [OUT_W-1:0] rd_data
);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_vec;
    logic       accept;
    logic       do_sample;
    logic [SIG_W-1:0] misr_word;
    logic [SIG_W-1:0] misr_nxt;

    assign last_vec  = &vec_out;
    assign accept    = (state == S_IDLE) && start && !abort;
    assign do_sample = (state == S_SAMPLE) && !abort;
    assign misr_word = SIG_W'({vec_out, dut_out});
    assign misr_nxt  = (signature << 1) ^ (signature[SIG_W-1] ? POLY : '0) ^ misr_word;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        vec_valid     = 1'b0;
        sample_strobe = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_APPLY;
            end
            S_APPLY: begin
                vec_valid = 1'b1;
                state_nxt = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                vec_valid = 1'b1;
                if (cnt == 4'd1) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                vec_valid     = 1'b1;
                sample_strobe = 1'b1;
                state_nxt     = last_vec ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // abort wins over every transition, including start in IDLE
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            vec_out    <= '0;
            signature  <= SEED;
            ones_count <= '0;
        end else begin
            if (state == S_APPLY)       cnt <= 4'(SETTLE);
            else if (state == S_SETTLE) cnt <= cnt - 4'd1;

            if (accept) begin
                vec_out    <= '0;
                signature  <= SEED;
                ones_count <= '0;
            end else if (do_sample) begin
                signature  <= misr_nxt;
                ones_count <= ones_count + (N_W+1)'(dut_out[0]);
                if (!last_vec) vec_out <= vec_out + 1'b1;
            end
        end
    end

`ifdef VSWEEP_LOG_EN
    logic [2**N_W-1:0][OUT_W-1:0] log_mem;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            log_mem <= '0;
            rd_data <= '0;
        end else begin
            if (do_sample) log_mem[vec_out] <= dut_out;
            rd_data <= log_mem[rd_addr];
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule
